// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: one shared handshaked memory port for
// fetch and data, holding PC, IR, ALUOut, MDR, store data and instret.
module multicycle_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ready,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic [31:0]      ir,
  output logic [XLEN-1:0]  pc,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_write,
  output logic [XLEN-1:0]  wb_data,
  output logic             halt,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic [31:0]      r_ir;
  logic [XLEN-1:0]  r_aluout;
  logic [XLEN-1:0]  r_mdr;
  logic [XLEN-1:0]  r_sdata;
  logic [CNT_W-1:0] r_instret;

  logic            w_is_r;
  logic            w_is_i;
  logic            w_is_lw;
  logic            w_is_sw;
  logic            w_is_beq;
  logic            w_is_jal;
  logic            w_legal;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_plus_imm;
  logic            w_unused;

  // Source operand A goes straight from the register file to the ALU.
  assign w_unused = ^rs1_data;

  always_comb begin
    w_is_r   = 1'b0;
    w_is_i   = 1'b0;
    w_is_lw  = 1'b0;
    w_is_sw  = 1'b0;
    w_is_beq = 1'b0;
    w_is_jal = 1'b0;
    case (r_ir[6:0])
      OP_R:    w_is_r   = 1'b1;
      OP_I:    w_is_i   = 1'b1;
      OP_LW:   w_is_lw  = 1'b1;
      OP_SW:   w_is_sw  = 1'b1;
      OP_BEQ:  w_is_beq = 1'b1;
      OP_JAL:  w_is_jal = 1'b1;
      default: ;
    endcase
  end

  assign w_legal = w_is_r | w_is_i | w_is_lw
                 | w_is_sw | w_is_beq | w_is_jal;

  assign w_pc_plus4    = r_pc + XLEN'(4);
  assign w_pc_plus_imm = r_pc + imm;

  always_comb begin
    alu_op  = 2'b00;
    alu_src = 1'b0;
    unique case (1'b1)
      w_is_r:   alu_op = 2'b10;
      w_is_i: begin
        alu_op  = 2'b10;
        alu_src = 1'b1;
      end
      w_is_lw,
      w_is_sw:  alu_src = 1'b1;
      w_is_beq: alu_op = 2'b01;
      default: ;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      w_is_lw:  wb_data = r_mdr;
      w_is_jal: wb_data = w_pc_plus4;
      default:  wb_data = r_aluout;
    endcase
  end

  // Bus outputs decode from the state register so reset drops them at once.
  assign mem_req   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign mem_we    = (r_state == S_MEM) && w_is_sw;
  assign mem_wdata = mem_we ? r_sdata : '0;

  always_comb begin
    mem_addr = '0;
    if (r_state == S_FETCH) mem_addr = r_pc;
    else if (r_state == S_MEM) mem_addr = r_aluout;
  end

  assign reg_write = (r_state == S_WB);
  assign halt      = (r_state == S_TRAP);
  assign ir        = r_ir;
  assign pc        = r_pc;
  assign instret   = r_instret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_aluout  <= '0;
      r_mdr     <= '0;
      r_sdata   <= '0;
      r_instret <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= mem_rdata[31:0];
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          r_aluout <= alu_result;
          r_sdata  <= rs2_data;
          unique case (1'b1)
            w_is_beq: begin
              r_pc      <= alu_zero ? w_pc_plus_imm : w_pc_plus4;
              r_instret <= r_instret + CNT_W'(1);
              r_state   <= S_FETCH;
            end
            w_is_lw,
            w_is_sw: r_state <= S_MEM;
            default: r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (w_is_sw) begin
              r_pc      <= w_pc_plus4;
              r_instret <= r_instret + CNT_W'(1);
              r_state   <= S_FETCH;
            end else begin
              r_mdr   <= mem_rdata;
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_pc      <= w_is_jal ? w_pc_plus_imm : w_pc_plus4;
          r_instret <= r_instret + CNT_W'(1);
          r_state   <= S_FETCH;
        end
        S_TRAP: r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: external regfile/immgen/ALU/memory around
// the DUT, checked per instruction against an ISA-level model.
module tb_multicycle_sequencer;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam int K_R = 0, K_I = 1, K_LW = 2;
  localparam int K_SW = 3, K_BEQ = 4, K_JAL = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] rs1_data, rs2_data, imm, alu_result;
  logic        alu_zero, alu_src, reg_write, halt;
  logic [31:0] ir, pc, wb_data, instret;
  logic [1:0]  alu_op;

  multicycle_sequencer #(
    .XLEN(32), .RESET_PC(RST_PC), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .alu_result(alu_result), .alu_zero(alu_zero),
    .ir(ir), .pc(pc), .alu_op(alu_op), .alu_src(alu_src),
    .reg_write(reg_write), .wb_data(wb_data),
    .halt(halt), .instret(instret)
  );

  always #5 clk = ~clk;

  // External datapath blocks
  logic [31:0] rf [32] = '{default: 32'h0};
  logic [31:0] alu_b;

  always @(posedge clk)
    if (reg_write && ir[11:7] != 5'd0) rf[ir[11:7]] <= wb_data;

  assign rs1_data = rf[ir[19:15]];
  assign rs2_data = rf[ir[24:20]];

  always_comb begin
    case (ir[6:0])
      7'b0010011, 7'b0000011:
        imm = {{20{ir[31]}}, ir[31:20]};
      7'b0100011: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011:
        imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b1101111:
        imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

  assign alu_b = alu_src ? imm : rs2_data;

  always_comb begin
    case (alu_op)
      2'b00: alu_result = rs1_data + alu_b;
      2'b01: alu_result = rs1_data - alu_b;
      default: begin
        case (ir[14:12])
          3'b111:  alu_result = rs1_data & alu_b;
          3'b110:  alu_result = rs1_data | alu_b;
          3'b100:  alu_result = rs1_data ^ alu_b;
          default: alu_result = (ir[5] && ir[30]) ?
                                rs1_data - alu_b : rs1_data + alu_b;
        endcase
      end
    endcase
  end

  assign alu_zero = (alu_result == 32'h0);

  logic [31:0] env_mem [logic [31:0]];

  // Reference model state
  logic [31:0] ref_rf [32] = '{default: 32'h0};
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_pc;
  logic [31:0] ref_ret;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit abort = 1'b0;

  int g_kind, g_rd, g_rs1, g_rs2, g_f;
  logic [31:0] g_imm;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // f: 0 add, 1 sub, 2 and, 3 or, 4 xor
  function automatic logic [31:0] op_ref(int f, logic [31:0] a,
                                         logic [31:0] b);
    case (f)
      1:       return a - b;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [2:0] f3_of(int f);
    case (f)
      2:       return 3'b111;
      3:       return 3'b110;
      4:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] encode();
    logic [4:0] rd, r1, r2;
    rd = 5'(g_rd);
    r1 = 5'(g_rs1);
    r2 = 5'(g_rs2);
    case (g_kind)
      K_R: return {(g_f == 1) ? 7'b0100000 : 7'b0, r2, r1,
                   f3_of(g_f), rd, 7'b0110011};
      K_I: return {g_imm[11:0], r1, f3_of(g_f), rd, 7'b0010011};
      K_LW: return {g_imm[11:0], r1, 3'b010, rd, 7'b0000011};
      K_SW: return {g_imm[11:5], r2, r1, 3'b010,
                    g_imm[4:0], 7'b0100011};
      K_BEQ: return {g_imm[12], g_imm[10:5], r2, r1, 3'b000,
                     g_imm[4:1], g_imm[11], 7'b1100011};
      default: return {g_imm[20], g_imm[10:1], g_imm[11],
                       g_imm[19:12], rd, 7'b1101111};
    endcase
  endfunction

  task automatic set_ins(input int k, rd, r1, r2, f,
                         input logic [31:0] im);
    g_kind = k; g_rd = rd; g_rs1 = r1; g_rs2 = r2;
    g_f = f; g_imm = im;
  endtask

  task automatic rand_ins();
    logic [31:0] r;
    int v;
    r = $urandom;
    v = $urandom_range(0, 9);
    g_kind = (v < 3) ? K_I : (v < 5) ? K_R : (v == 5) ? K_LW :
             (v == 6) ? K_SW : (v < 9) ? K_BEQ : K_JAL;
    g_rd  = $urandom_range(0, 7);
    g_rs1 = $urandom_range(0, 7);
    g_rs2 = $urandom_range(0, 7);
    g_f   = $urandom_range(0, 4);
    g_imm = {{20{r[11]}}, r[11:0]};
    case (g_kind)
      K_I: if (g_f == 1) g_f = 0;
      K_LW, K_SW:
        if (r[31]) begin
          g_rs1 = 0;
          g_imm = {27'b0, r[4:2], 2'b00};
        end
      K_BEQ: begin
        g_rs1 = $urandom_range(0, 3);
        g_rs2 = r[30] ? g_rs1 : $urandom_range(0, 3);
        g_imm = {{19{r[11]}}, r[11:0], 1'b0};
      end
      K_JAL: g_imm = {{11{r[19]}}, r[19:0], 1'b0};
      default: ;
    endcase
  endtask

  // Entered at a falling edge with the DUT presenting a fetch.
  task automatic run_instr(input int fw, input int mw);
    logic [31:0] ins, a, b, exp_wb, exp_addr, exp_wdata, npc;
    logic [31:0] prev_ret;
    int base, nwr, cnt, mleft;
    bit exp_wr, is_mem, is_st, done;
    if (abort) return;
    ins = encode();
    a = ref_rf[g_rs1];
    b = ref_rf[g_rs2];
    exp_wb = 0; exp_addr = 0; exp_wdata = 0;
    exp_wr = 0; is_mem = 0; is_st = 0;
    npc = ref_pc + 4;
    base = 4;
    case (g_kind)
      K_R: begin exp_wb = op_ref(g_f, a, b); exp_wr = 1; end
      K_I: begin exp_wb = op_ref(g_f, a, g_imm); exp_wr = 1; end
      K_LW: begin
        exp_addr = a + g_imm;
        exp_wb = ref_mem.exists(exp_addr) ? ref_mem[exp_addr] : 0;
        exp_wr = 1; is_mem = 1; base = 5;
      end
      K_SW: begin
        exp_addr = a + g_imm;
        exp_wdata = b;
        ref_mem[exp_addr] = b;
        is_mem = 1; is_st = 1;
      end
      K_BEQ: begin
        if (a == b) npc = ref_pc + g_imm;
        base = 3;
      end
      default: begin
        exp_wb = ref_pc + 4; exp_wr = 1;
        npc = ref_pc + g_imm;
      end
    endcase
    if (exp_wr && g_rd != 0) ref_rf[g_rd] = exp_wb;

    chk("fetch_req", {mem_req, mem_we}, 2'b10);
    chk("fetch_addr", mem_addr, ref_pc);
    prev_ret = instret;
    cnt = 1;
    for (int k = 0; k < fw; k++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      @(negedge clk); cnt++;
      chk("fetch_hold", {mem_req, mem_we, mem_addr}, {2'b10, ref_pc});
    end
    mem_ready = 1'b1;
    mem_rdata = ins;
    @(negedge clk); cnt++;
    chk("ir", ir, ins);
    nwr = 0; mleft = mw; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (instret != prev_ret) done = 1;
      else begin
        if (reg_write) begin
          nwr++;
          chk("wb_data", wb_data, exp_wb);
        end
        if (mem_req) begin
          chk("mem_phase", is_mem, 1);
          chk("mem_addr", mem_addr, exp_addr);
          chk("mem_we", mem_we, is_st);
          if (is_st) chk("mem_wdata", mem_wdata, exp_wdata);
          if (mleft > 0) begin
            mleft--;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
          end else begin
            mem_ready = 1'b1;
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : 0;
          end
        end else begin
          chk("idle_bus", {mem_addr, mem_wdata}, 64'h0);
          mem_ready = 1'($urandom);
          mem_rdata = $urandom;
        end
        @(negedge clk); cnt++;
      end
    end
    chk("retired", done, 1);
    if (!done) begin
      abort = 1'b1;
      return;
    end
    ref_ret = ref_ret + 1;
    chk("latency", cnt - 1, base + fw + (is_mem ? mw : 0));
    chk("pc", pc, npc);
    chk("instret", instret, ref_ret);
    chk("reg_writes", nwr, exp_wr);
    if (exp_wr && g_rd != 0) chk("rf", rf[g_rd], ref_rf[g_rd]);
    ref_pc = npc;
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    ref_pc = RST_PC;
    ref_ret = 0;

    @(negedge clk);
    chk("rst_bus", {mem_req, mem_we, mem_addr, mem_wdata}, 66'h0);
    chk("rst_flags", {reg_write, halt}, 2'b00);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", ir, 32'h0);
    chk("rst_instret", instret, 32'h0);
    mem_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_no_req", mem_req, 0);
    mem_ready = 1'b0;
    @(negedge clk);

    // ADDI x1,x0,5 / ADD x2,x1,x1 / SW x2,0(x0) / LW x3,0(x0)
    set_ins(K_I, 1, 0, 0, 0, 32'd5);   run_instr(0, 0);
    set_ins(K_R, 2, 1, 1, 0, 32'd0);   run_instr(0, 0);
    set_ins(K_SW, 0, 0, 2, 0, 32'd0);  run_instr(0, 0);
    set_ins(K_LW, 3, 0, 0, 0, 32'd0);  run_instr(0, 0);
    chk("prog_x3", rf[3], 32'd10);
    chk("prog_instret", instret, 32'd4);
    chk("prog_pc", pc, 32'h10);

    set_ins(K_BEQ, 0, 0, 0, 0, 32'd8); run_instr(0, 0);
    chk("beq_taken_pc", pc, 32'h18);
    set_ins(K_BEQ, 0, 1, 0, 0, 32'd8); run_instr(0, 0);
    chk("beq_not_taken_pc", pc, 32'h1C);
    set_ins(K_I, 0, 0, 0, 0, 32'd0);   run_instr(0, 0);
    set_ins(K_JAL, 1, 0, 0, 0, 32'h100); run_instr(0, 0);
    chk("jal_link", rf[1], 32'h24);
    chk("jal_pc", pc, 32'h120);

    set_ins(K_I, 4, 0, 0, 0, 32'd7);   run_instr(3, 0);
    set_ins(K_SW, 0, 0, 4, 0, 32'h8);  run_instr(1, 3);
    set_ins(K_LW, 5, 0, 0, 0, 32'h8);  run_instr(2, 2);

    for (int n = 0; n < 300; n++) begin
      rand_ins();
      run_instr(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    // Reset lands while a store waits in MEM
    chk("pre_rst_instret_nz", instret != 0, 1);
    set_ins(K_SW, 0, 0, 2, 0, 32'h40);
    chk("sw_fetch_addr", mem_addr, ref_pc);
    mem_ready = 1'b1;
    mem_rdata = encode();
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sw_mem_req", {mem_req, mem_we}, 2'b11);
    @(negedge clk);
    chk("sw_mem_hold", {mem_req, mem_we}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_req", {mem_req, mem_we, mem_addr}, 34'h0);
    chk("rst_async_pc", pc, RST_PC);
    chk("rst_async_instret", instret, 32'h0);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_idle_req", mem_req, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    ref_pc = RST_PC;
    ref_ret = 0;

    // Illegal opcode traps and stays put
    chk("trap_fetch", {mem_req, mem_we, mem_addr}, {2'b10, RST_PC});
    mem_ready = 1'b1;
    mem_rdata = 32'h0000007F;
    @(negedge clk); mem_ready = 1'b0;
    chk("decode_no_halt", halt, 0);
    for (int i = 0; i < 24; i++) begin
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      chk("trap_halt", halt, 1);
      chk("trap_quiet", {mem_req, reg_write, mem_addr}, 34'h0);
      chk("trap_instret", instret, 32'h0);
      chk("trap_pc", pc, RST_PC);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

- Multi-cycle RV32I control sequencer and architectural-state holder for the next-generation core.
- Replaces the single-cycle control path with an FSM that fetches and accesses data through one shared, handshaked memory port.
- Owns PC, IR, ALUOut, MDR, store-data and a retired-instruction counter.
- Drives the existing immediate generator, register file, ALU control and ALU, which stay external.

## Interface

Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 0, PC value loaded by reset
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = store, 0 = load/fetch; valid while mem_req
- mem_addr  out  XLEN  request address
- mem_wdata  out  XLEN  store data
- mem_rdata  in  XLEN  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  request accepted/completed this cycle
- rs1_data, rs2_data  in  XLEN  register file read data
- imm  in  XLEN  immediate-generator output for current ir
- alu_result  in  XLEN  ALU output
- alu_zero  in  1  ALU zero flag
- ir  out  32  latched instruction
- pc  out  XLEN  current instruction address
- alu_op  out  2  00 add (LW/SW), 01 sub (BEQ), 10 funct-decoded (R/I)
- alu_src  out  1  ALU B operand: 1 = imm, 0 = rs2_data
- reg_write  out  1  register file write enable
- wb_data  out  XLEN  register write-back value
- halt  out  1  sticky illegal-opcode flag
- instret  out  CNT_W  retired-instruction count

## Operation

- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (async):
  - state=IDLE, pc=RESET_PC, ir=0, ALUOut=MDR=store-data=0, instret=0.
  - Outputs: mem_req=0, mem_we=0, reg_write=0, halt=0.
  - IDLE → FETCH on the first clock edge after reset deasserts.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ready: ir←mem_rdata, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle for register/immediate read. Opcode ir[6:0]:
  - 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ, 1101111 JAL → EXEC.
  - Any other opcode → TRAP.
- EXEC, per opcode:
  - R: alu_op=10, alu_src=0.
  - I-ALU: alu_op=10, alu_src=1.
  - LW/SW: alu_op=00, alu_src=1.
  - BEQ: alu_op=01, alu_src=0.
  - JAL: no ALU use.
  - Every opcode: ALUOut←alu_result, store-data←rs2_data.
  - BEQ: pc←(alu_zero ? pc+imm : pc+4), retire, go to FETCH.
  - JAL: go to WB.
  - LW/SW: go to MEM. R/I-ALU: go to WB.
- MEM:
  - mem_req=1, mem_addr=ALUOut.
  - mem_we=1 for SW with mem_wdata=store-data; mem_we=0 for LW.
  - On mem_ready, LW: MDR←mem_rdata, go to WB.
  - On mem_ready, SW: pc←pc+4, retire, go to FETCH.
- WB: reg_write=1 for exactly one cycle.
  - wb_data: ALUOut for R/I-ALU, MDR for LW, pc+4 for JAL.
  - pc←(JAL ? pc+imm : pc+4), retire, go to FETCH.
- TRAP: halt=1, mem_req=0, reg_write=0. Held until reset; pc and instret frozen.
- Retire means instret←instret+1. The counter wraps modulo 2^CNT_W.
- PC arithmetic is modulo 2^XLEN; pc+imm and pc+4 wrap silently.
- mem_addr=0 and mem_wdata=0 whenever mem_req=0.

## Timing

- Latency with mem_ready=1 on the first request cycle:
  - BEQ 3 cycles
  - R, I-ALU, SW, JAL 4 cycles
  - LW 5 cycles
- Each wait cycle in FETCH or MEM adds exactly one cycle.
- Handshake: mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the cycle mem_ready=1, and deassert or change the following cycle.
- mem_ready while mem_req=0 is ignored.
- Reset during FETCH/MEM: mem_req drops asynchronously. No write completes, and no ir or MDR update occurs.
- reg_write is combinational from state and never asserts outside WB.
- pc, ir and instret change only on the rising edge that leaves the retiring state.

## Test plan

- Zero-wait memory, program ADDI x1,x0,5 / ADD x2,x1,x1 / SW x2,0(x0) / LW x3,0(x0): retires at cycles 4, 8, 12, 17. x3 is written with 10, instret=4, and the LW's MEM cycle has mem_addr=0.
- BEQ x0,x0,+8 at pc=0x10: after 3 cycles pc=0x18, no reg_write. BEQ with unequal operands: pc=0x14.
- JAL x1,+0x100 at pc=0x20: WB writes wb_data=0x24, next fetch address is 0x120.
- mem_ready held low 3 cycles during FETCH: mem_addr stays constant, and the instruction retires 3 cycles later than with zero wait.
- Opcode 0x7F fetched: halt=1 from TRAP onward, mem_req stays 0 for 20+ cycles, instret unchanged.
- Reset asserted mid-MEM of an SW: mem_req=0 immediately, pc=RESET_PC, instret=0. After deassert, FETCH from RESET_PC follows IDLE.
